serial_add_seq: RTL and testbench
=================================

# serial_add_seq

Bit-serial adder controller that accepts two WIDTH-bit operands over a valid/ready handshake. It sequences them LSB-first, one bit per clock, through a 1-bit full-adder cell built from two half adders, then presents the sum and carry-out over a second valid/ready handshake. It sits between a host-side operand source and the result sink. It trades WIDTH+2 cycles of latency for a single-bit datapath.

## Interface
Parameters:
- WIDTH, 8: operand and sum width in bits; legal range 1..32.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept an operand pair.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- op_sub  in  1  1 = compute A−B. Present only with SERIAL_ADD_SUB_EN.
- out_valid  out  1  sum and carry_out are valid.
- out_ready  in  1  sink accepts the result.
- sum  out  WIDTH  result, registered.
- carry_out  out  1  final carry. For subtraction, 1 = no borrow.
- busy  out  1  high in RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready:
    - latch op_a and op_b into shift registers;
    - clear the bit counter;
    - set the carry register to 0 (or to op_sub under the macro);
    - go to RUN.
- RUN:
  - One bit per cycle:
    - s = a0 ^ b' ^ c;
    - c_next = (a0 & b') | (c & (a0 ^ b')), where b' = b0, or ~b0 when subtracting;
    - the A and B registers shift right;
    - s shifts into the sum register at the MSB.
  - The counter runs 0..WIDTH-1.
  - When the counter reaches WIDTH-1, go to DONE and load carry_out with c_next.
- DONE:
  - out_valid=1.
  - sum and carry_out are held stable while out_ready=0.
  - On out_ready, go to IDLE.
- Ignored inputs:
  - in_valid outside IDLE is ignored; no queueing.
  - out_ready outside DONE has no effect.
- Arithmetic is modulo 2^WIDTH. The overflow bit appears only on carry_out.
- Counter width is max(1, $clog2(WIDTH)). It never wraps, because the RUN exit is taken at WIDTH-1.
- WIDTH=1: RUN lasts exactly one cycle.

## Timing
- Reset values: in_ready=0 during the reset cycle, then 1 in IDLE; out_valid=0; busy=0; sum=0; carry_out=0. The state register resets to IDLE, the counter to 0, the carry to 0.
- Reset mid-RUN or mid-DONE:
  - the next cycle is IDLE with all outputs at reset values;
  - any in-flight result is discarded.
- Latency: accept edge at cycle T gives RUN during T+1..T+WIDTH, with out_valid first high in cycle T+WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles when out_ready is tied high. There is no overlap of accept and result.
- The output handshake completes on the rising edge where out_valid && out_ready. in_ready rises the following cycle.
- sum and carry_out keep their last value after leaving DONE until the next DONE load. They are qualified only by out_valid.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - the op_sub port exists and is latched at accept;
  - subtraction inverts each B bit and seeds the carry with 1.
- SERIAL_ADD_SUB_EN undefined:
  - there is no op_sub port;
  - the carry is always seeded with 0;
  - the B inversion logic is absent.

## Structure
- Package serial_add_pkg holds:
  - the state typedef with encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the default WIDTH constant.
- Sub-module serial_fa_cell:
  - a combinational 1-bit full adder composed of two half-adder stages;
  - inputs a, b, cin; outputs s, cout.
  - The controller instantiates it once.

## Test plan
- WIDTH=8, accept A=0x5A, B=0x33 at T with out_ready=1 -> out_valid at T+9, sum=0x8D, carry_out=0, back to IDLE at T+10.
- A=0xFF, B=0x01 -> sum=0x00, carry_out=1. A=0x00, B=0x00 -> sum=0x00, carry_out=0.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid, sum and carry_out stable for all 5 cycles; in_ready=0 throughout.
- Pulse in_valid with new operands during RUN -> not accepted, in_ready=0, first result unchanged.
- Assert rst for one cycle at RUN bit 3 -> next cycle IDLE, out_valid=0, sum=0, busy=0. A fresh 0x01+0x01 then yields 0x02.
- With SERIAL_ADD_SUB_EN defined:
  - 0x10−0x01 -> sum=0x0F, carry_out=1;
  - 0x00−0x01 -> sum=0xFF, carry_out=0.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder built from two cascaded half-adder stages.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p1;
  logic g1;
  logic g2;

  // First half adder combines the operand bits, second folds in the carry.
  assign p1   = a ^ b;
  assign g1   = a & b;
  assign s    = p1 ^ cin;
  assign g2   = p1 & cin;
  assign cout = g1 | g2;

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder controller: LSB-first through one full-adder cell, WIDTH+2 cycles per op.
// Optional subtraction (op_sub port, B inversion, carry seed) enabled by SERIAL_ADD_SUB_EN.
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             carry_seed;
  logic             accept;
  logic             run;
  logic             last_bit;
  logic             fa_b;
  logic             fa_s;
  logic             fa_cout;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_q;

  assign fa_b       = b_sh[0] ^ sub_q;
  assign carry_seed = op_sub;
`else
  assign fa_b       = b_sh[0];
  assign carry_seed = 1'b0;
`endif

  assign accept   = in_valid && in_ready;
  assign run      = (state == RUN);
  assign last_bit = (cnt == LAST_BIT);

  serial_fa_cell u_fa (
    .a    (a_sh[0]),
    .b    (fa_b),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Sum bits enter at the MSB so the LSB computed first ends up at bit 0.
  always_comb begin
    acc_next            = acc >> 1;
    acc_next[WIDTH-1]   = fa_s;
  end

  // NOTE: every output and next-state gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      carry     <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      carry <= carry_seed;
    end else if (run) begin
      cnt   <= cnt + CNT_W'(1);
      carry <= fa_cout;
      if (last_bit) begin
        sum       <= acc_next;
        carry_out <= fa_cout;
      end
    end
  end

  // NOTE: operand and accumulator shifters carry no reset; they are always
  // reloaded at accept and fully shifted before the result is captured.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh <= op_a;
      b_sh <= op_b;
`ifdef SERIAL_ADD_SUB_EN
      sub_q <= op_sub;
`endif
    end else if (run) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      acc  <= acc_next;
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq: directed cases, then randomized ops vs arithmetic model.
module tb_serial_add_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
`ifdef SERIAL_ADD_SUB_EN
  logic         op_sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  serial_add_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
`ifdef SERIAL_ADD_SUB_EN
    .op_sub    (op_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Result as defined arithmetically: modulo 2^W sum, carry = overflow or "no borrow".
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub,
                                output logic [W-1:0] s, output logic c);
    longint unsigned r;
    if (sub) begin
      s = W'(longint'(a) - longint'(b));
      c = (a >= b);
    end else begin
      r = longint'(a) + longint'(b);
      s = W'(r);
      c = r[W];
    end
  endfunction

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub,
                       input int hold, input bit intrude, input string tag);
    logic [W-1:0] es;
    logic         ec;
    int           n;
    model(a, b, sub, es, ec);
    check({tag, " ready_pre"}, 32'(in_ready), 32'd1);
    op_a      = a;
    op_b      = b;
`ifdef SERIAL_ADD_SUB_EN
    op_sub    = sub;
`endif
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    tick();
    in_valid = 1'b0;
    check({tag, " busy_run"}, 32'(busy), 32'd1);
    check({tag, " ready_run"}, 32'(in_ready), 32'd0);
    n = 0;
    while (out_valid !== 1'b1 && n < 4 * W) begin
      if (intrude && n == 2) begin
        in_valid = 1'b1;
        op_a     = W'($urandom);
        op_b     = W'($urandom);
      end
      tick();
      n++;
      if (intrude && in_valid) check({tag, " ready_intrude"}, 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check({tag, " latency"}, 32'(n), 32'(W));
    check({tag, " sum"}, 32'(sum), 32'(es));
    check({tag, " carry"}, 32'(carry_out), 32'(ec));
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, " hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, " hold_sum"}, 32'(sum), 32'(es));
      check({tag, " hold_carry"}, 32'(carry_out), 32'(ec));
      check({tag, " hold_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check({tag, " valid_after"}, 32'(out_valid), 32'd0);
    check({tag, " ready_after"}, 32'(in_ready), 32'd1);
    check({tag, " busy_after"}, 32'(busy), 32'd0);
    check({tag, " sum_kept"}, 32'(sum), 32'(es));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    bit           rs;
    rst       = 1'b1;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    out_ready = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    op_sub    = 1'b0;
`endif
    tick();
    tick();
    check("rst ready", 32'(in_ready), 32'd0);
    check("rst valid", 32'(out_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst sum", 32'(sum), 32'd0);
    check("rst carry", 32'(carry_out), 32'd0);
    rst = 1'b0;
    #1;
    check("idle ready", 32'(in_ready), 32'd1);

    do_op(8'h5A, 8'h33, 1'b0, 0, 1'b0, "add_5a_33");
    do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0, "add_ff_01");
    do_op(8'h00, 8'h00, 1'b0, 0, 1'b0, "add_00_00");
    do_op(8'hC7, 8'h9E, 1'b0, 5, 1'b0, "hold5");
    do_op(8'h12, 8'h34, 1'b0, 0, 1'b1, "intrude");
    do_op(8'hF0, 8'h20, 1'b0, 1, 1'b0, "pre_rst");

    // Reset asserted for one cycle while the counter is at bit 3.
    op_a     = 8'hAB;
    op_b     = 8'hCD;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("midrst valid", 32'(out_valid), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst sum", 32'(sum), 32'd0);
    check("midrst carry", 32'(carry_out), 32'd0);
    check("midrst ready", 32'(in_ready), 32'd1);
    do_op(8'h01, 8'h01, 1'b0, 0, 1'b0, "post_rst");

`ifdef SERIAL_ADD_SUB_EN
    do_op(8'h10, 8'h01, 1'b1, 0, 1'b0, "sub_10_01");
    do_op(8'h00, 8'h01, 1'b1, 0, 1'b0, "sub_00_01");
    do_op(8'h37, 8'h37, 1'b1, 1, 1'b0, "sub_eq");
`endif

    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      do_op(ra, rb, rs, int'($urandom_range(0, 2)), 1'($urandom), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
